// File: rtl/rom_burst_reader.sv
// Burst read sequencer for a synchronous ROM: issues addresses, absorbs the
// 1-cycle read latency and streams words through a 2-entry buffer. Optional csum via ROM_BURST_CHECKSUM_EN.
module rom_burst_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   length,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] rom_addr,
  output logic             rom_re,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
`ifdef ROM_BURST_CHECKSUM_EN
  output logic [WIDTH-1:0] csum,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a word transfers on every edge where m_valid && m_ready; while
  // m_valid && !m_ready, m_data and m_last are held unchanged.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [DEPTH:0] REMAIN_ONE = 1;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [DEPTH:0]   remain_q, remain_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] buf_data_q [2];
  logic [WIDTH-1:0] buf_data_d [2];
  logic             buf_last_q [2];
  logic             buf_last_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic             pop;
  logic             push;
  logic             start_accept;
  logic [2:0]       occ;

  assign pop          = (cnt_q != 2'd0) && m_ready;
  assign push         = inflight_q;
  assign start_accept = (state_q == IDLE) && start;
  // Words already committed to the buffer after this cycle's pop.
  assign occ          = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    done_d          = 1'b0;
    rom_re          = 1'b0;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (start_accept) begin
          if (length != '0) begin
            addr_d   = base_addr;
            remain_d = length;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if ((remain_q != '0) && (occ < 3'd2)) begin
          rom_re   = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == REMAIN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && buf_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inflight_d      = rom_re;
    inflight_last_d = rom_re && (remain_q == REMAIN_ONE);

    if (push) begin
      buf_data_d[wr_ptr_q] = rom_data;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      cnt_q           <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rom_addr  = addr_q;
  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = buf_data_q[rd_ptr_q];
  assign m_last    = m_valid && buf_last_q[rd_ptr_q];
  assign dbg_state = state_q;

`ifdef ROM_BURST_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (pop) csum_d = csum_q ^ m_data;
    if (start_accept) csum_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule
